shift_unit_iter: RTL

SHIFT_UNIT_ITER -- requirements
Module: shift_unit_iter

---
 rtl/shift_unit_iter.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/shift_unit_iter.sv
// shift_unit_iter -- iterative shifter/rotator with a valid/ready handshake.
//
// A request (op, data, shamt) is captured when in_valid && in_ready. The
// operand is then shifted by up to STEP bits per cycle. When shamt reaches
// zero, the result and flags are presented with out_valid. They stay there
// until the consumer raises out_ready.
//
// Parameters:
//   WIDTH  operand/result width (8..64, power of two)
//   STEP   maximum bits shifted per cycle (1..WIDTH, power of two)
//
// Configuration macro:
//   SHIFT_ROTATE_EN  when defined, ROL/ROR are supported. When undefined,
//                    op 100/101 are illegal and no rotate logic is built.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   block idle and able to accept a request
//   op         000 SHL, 001 SHR, 010 SAR, 011 SAL, 100 ROL, 101 ROR
//   data       operand
//   shamt      shift amount, 0..WIDTH-1
//   out_valid  result present
//   out_ready  consumer accepts the result
//   result     shifted/rotated value (the operand itself for illegal ops)
//   carry      last bit shifted or rotated out of the word
//   overflow   SAL only: a bit passing through the MSB differed from the sign
//   zero       result == 0
//   neg        result MSB
//   illegal    op not supported
module shift_unit_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     carry,
  output logic                     overflow,
  output logic                     zero,
  output logic                     neg,
  output logic                     illegal
);

  localparam int SW = $clog2(WIDTH);
  // STEP may equal WIDTH, so it needs one extra bit to compare against rem_r.
  localparam logic [SW:0] STEP_W = (SW+1)'(STEP);

  localparam logic [2:0] OP_SHL = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SAR = 3'b010;
  localparam logic [2:0] OP_SAL = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Reports whether an opcode is supported in this build.
  function automatic logic op_legal(input logic [2:0] o);
    case (o)
      OP_SHL, OP_SHR, OP_SAR, OP_SAL: op_legal = 1'b1;
`ifdef SHIFT_ROTATE_EN
      OP_ROL, OP_ROR:                 op_legal = 1'b1;
`endif
      default:                        op_legal = 1'b0;
    endcase
  endfunction

  state_t           state_r, state_n;
  logic [WIDTH-1:0] work_r, work_n;
  logic [SW-1:0]    rem_r, rem_n;
  logic [2:0]       op_r, op_n;
  logic             sign_r, sign_n;
  logic             carry_r, carry_n;
  logic             ovf_r, ovf_n;
  logic             zero_r, zero_n;
  logic             neg_r, neg_n;
  logic             ill_r, ill_n;
  logic             valid_r, ready_r;

  logic [SW-1:0]    k_s;
  logic [WIDTH:0]   lsh_s;   // [WIDTH] holds the bit pushed out at the MSB end
  logic [WIDTH:0]   rsh_s;   // [0] holds the bit pushed out at the LSB end
  logic [WIDTH:0]   sar_s;
  logic [WIDTH-1:0] step_val_s;
  logic             step_carry_s;
  logic             step_ovf_s;
`ifdef SHIFT_ROTATE_EN
  logic [2*WIDTH-1:0] rol_s;
  logic [2*WIDTH-1:0] ror_s;
`endif

  // Per-cycle shift datapath: one step of k = min(STEP, remaining) bits.
  always_comb begin
    if ({1'b0, rem_r} > STEP_W) begin
      k_s = STEP_W[SW-1:0];
    end else begin
      k_s = rem_r;
    end
    lsh_s = {1'b0, work_r} << k_s;
    rsh_s = {work_r, 1'b0} >> k_s;
    sar_s = $unsigned($signed({work_r, 1'b0}) >>> k_s);
`ifdef SHIFT_ROTATE_EN
    rol_s = {work_r, work_r} << k_s;
    ror_s = {work_r, work_r} >> k_s;
`endif
    step_val_s   = work_r;
    step_carry_s = 1'b0;
    step_ovf_s   = 1'b0;
    case (op_r)
      OP_SHL, OP_SAL: begin
        step_val_s   = lsh_s[WIDTH-1:0];
        step_carry_s = lsh_s[WIDTH];
      end
      OP_SHR: begin
        step_val_s   = rsh_s[WIDTH:1];
        step_carry_s = rsh_s[0];
      end
      OP_SAR: begin
        step_val_s   = sar_s[WIDTH:1];
        step_carry_s = sar_s[0];
      end
`ifdef SHIFT_ROTATE_EN
      OP_ROL: begin
        step_val_s   = rol_s[2*WIDTH-1:WIDTH];
        step_carry_s = lsh_s[WIDTH];
      end
      OP_ROR: begin
        step_val_s   = ror_s[WIDTH-1:0];
        step_carry_s = rsh_s[0];
      end
`endif
      default: begin
        step_val_s   = work_r;
        step_carry_s = 1'b0;
      end
    endcase
    // The bits that occupy the MSB during this step are work_r[W-1 .. W-1-k].
    // This includes the new MSB.
    for (int i = 0; i < WIDTH; i++) begin
      if ((op_r == OP_SAL) && (i <= int'(k_s)) && (work_r[WIDTH-1-i] != sign_r)) begin
        step_ovf_s = 1'b1;
      end else begin
        step_ovf_s = step_ovf_s;
      end
    end
  end

  // Next-state and next-datapath logic for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_n = state_r;
    work_n  = work_r;
    rem_n   = rem_r;
    op_n    = op_r;
    sign_n  = sign_r;
    carry_n = carry_r;
    ovf_n   = ovf_r;
    zero_n  = zero_r;
    neg_n   = neg_r;
    ill_n   = ill_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          op_n    = op;
          work_n  = data;
          rem_n   = shamt;
          sign_n  = data[WIDTH-1];
          carry_n = 1'b0;
          ovf_n   = 1'b0;
          ill_n   = !op_legal(op);
          if (!op_legal(op) || (shamt == {SW{1'b0}})) begin
            state_n = DONE;
            zero_n  = (data == {WIDTH{1'b0}});
            neg_n   = data[WIDTH-1];
          end else begin
            state_n = SHIFT;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        work_n  = step_val_s;
        carry_n = step_carry_s;
        ovf_n   = ovf_r | step_ovf_s;
        rem_n   = rem_r - k_s;
        if (rem_r == k_s) begin
          state_n = DONE;
          zero_n  = (step_val_s == {WIDTH{1'b0}});
          neg_n   = step_val_s[WIDTH-1];
        end else begin
          state_n = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath, flag and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r  <= {WIDTH{1'b0}};
      rem_r   <= {SW{1'b0}};
      op_r    <= 3'b000;
      sign_r  <= 1'b0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
      ill_r   <= 1'b0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      work_r  <= work_n;
      rem_r   <= rem_n;
      op_r    <= op_n;
      sign_r  <= sign_n;
      carry_r <= carry_n;
      ovf_r   <= ovf_n;
      zero_r  <= zero_n;
      neg_r   <= neg_n;
      ill_r   <= ill_n;
      valid_r <= (state_n == DONE);
      ready_r <= (state_n == IDLE);
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign result    = work_r;
  assign carry     = carry_r;
  assign overflow  = ovf_r;
  assign zero      = zero_r;
  assign neg       = neg_r;
  assign illegal   = ill_r;

endmodule
